// File: rtl/width_down_converter.sv
// Single-clock DIN_W -> DOUT_W width down-converter with FWFT word buffer.
// Optional error counters: define WCONV_ERR_CNT_EN to add ovf_cnt/udf_cnt.
module width_down_converter #(
    parameter int DIN_W     = 16,
    parameter int DOUT_W    = 8,
    parameter int DEPTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DIN_W-1:0]           din,
    output logic                       full,
    input  logic                       rd_en,
    output logic [DOUT_W-1:0]          dout,
    output logic                       empty,
`ifdef WCONV_ERR_CNT_EN
    output logic [15:0]                ovf_cnt,
    output logic [15:0]                udf_cnt,
`endif
    output logic [$clog2(DEPTH):0]     level
);

    localparam int RATIO = DIN_W / DOUT_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((DIN_W % DOUT_W) != 0) begin : g_bad_ratio
        $error("DIN_W must be an integer multiple of DOUT_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end

    logic [DIN_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] beat_q, beat_d;

    logic wr_acc;
    logic rd_acc;
    logic last_beat;
    logic pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;

    assign wr_acc    = wr_en && !full;
    assign rd_acc    = rd_en && !empty;
    assign last_beat = (beat_q == BW'(RATIO - 1));
    assign pop       = rd_acc && last_beat;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            beat_d = last_beat ? '0 : beat_q + BW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    // A write and a pop on the same edge leave the word count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
        end
    end

    logic [DIN_W-1:0]  head;
    logic [DOUT_W-1:0] lanes [RATIO];
    logic [BW-1:0]     lane_sel;

    assign head = mem_q[rd_ptr_q];

    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        assign lanes[i] = head[i*DOUT_W +: DOUT_W];
    end

    always_comb begin
        if (MSB_FIRST) begin
            lane_sel = BW'(RATIO - 1) - beat_q;
        end else begin
            lane_sel = beat_q;
        end
    end

    assign dout = lanes[lane_sel];

`ifdef WCONV_ERR_CNT_EN
    logic [15:0] ovf_q, ovf_d;
    logic [15:0] udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (wr_en && full && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
        if (rd_en && empty && (udf_q != 16'hFFFF)) begin
            udf_d = udf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_cnt = ovf_q;
    assign udf_cnt = udf_q;
`endif

endmodule

// File: tb/tb_width_down_converter.sv
// Randomized bench for width_down_converter against a beat-queue model.
// Also checks a 32->8 LSB-first instance with directed vectors.
module tb_width_down_converter;

    localparam int R     = 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] din = '0;
    logic        rd_en = 1'b0;
    logic        full, empty;
    logic [7:0]  dout;
    logic [4:0]  level;

    logic        w32 = 1'b0;
    logic [31:0] d32 = '0;
    logic        r32 = 1'b0;
    logic        full32, empty32;
    logic [7:0]  dout32;
    logic [4:0]  level32;

`ifdef WCONV_ERR_CNT_EN
    logic [15:0] ovf_cnt, udf_cnt, ovf32, udf32;
    int          m_ovf, m_udf;
`endif

    always #5 clk = ~clk;

    width_down_converter dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .din(din), .full(full),
        .rd_en(rd_en), .dout(dout), .empty(empty),
`ifdef WCONV_ERR_CNT_EN
        .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt),
`endif
        .level(level)
    );

    width_down_converter #(
        .DIN_W(32), .DOUT_W(8), .DEPTH(16), .MSB_FIRST(1'b0)
    ) dut32 (
        .clk(clk), .rst(rst),
        .wr_en(w32), .din(d32), .full(full32),
        .rd_en(r32), .dout(dout32), .empty(empty32),
`ifdef WCONV_ERR_CNT_EN
        .ovf_cnt(ovf32), .udf_cnt(udf32),
`endif
        .level(level32)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_level();
        return (q.size() + R - 1) / R;
    endfunction

    task automatic check_outs();
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(m_level() == DEPTH));
        chk("level", 32'(level), 32'(m_level()));
        if (q.size() != 0) chk("dout", 32'(dout), 32'(q[0]));
`ifdef WCONV_ERR_CNT_EN
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        chk("udf_cnt", 32'(udf_cnt), 32'(m_udf));
`endif
    endtask

    task automatic step(input logic w, input logic [15:0] d, input logic r);
        bit m_full, m_empty;
        check_outs();
        m_full  = (m_level() == DEPTH);
        m_empty = (q.size() == 0);
        wr_en = w; din = d; rd_en = r;
        @(posedge clk);
        if (rst) begin
            q.delete();
`ifdef WCONV_ERR_CNT_EN
            m_ovf = 0; m_udf = 0;
`endif
        end else begin
`ifdef WCONV_ERR_CNT_EN
            if (w && m_full && m_ovf < 16'hFFFF) m_ovf++;
            if (r && m_empty && m_udf < 16'hFFFF) m_udf++;
`endif
            if (r && !m_empty) void'(q.pop_front());
            if (w && !m_full) begin
                q.push_back(d[15:8]);
                q.push_back(d[7:0]);
            end
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 100) begin
            step(1'b0, '0, 1'b1);
            guard++;
        end
        chk("drain_bound", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int maxlvl;
        logic [7:0] exp32 [4];
        exp32[0] = 8'h44; exp32[1] = 8'h33;
        exp32[2] = 8'h22; exp32[3] = 8'h11;

        #1;
        do_rst();
        do_rst();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);

        // 32->8 LSB-first instance
        w32 = 1'b1; d32 = 32'h11223344;
        @(posedge clk); #1;
        w32 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("w32_empty", 32'(empty32), 32'd0);
            chk("w32_level", 32'(level32), 32'd1);
            chk("w32_dout", 32'(dout32), 32'(exp32[i]));
            r32 = 1'b1;
            @(posedge clk); #1;
            r32 = 1'b0;
        end
        chk("w32_empty_end", 32'(empty32), 32'd1);
        chk("w32_level_end", 32'(level32), 32'd0);

        // basic single word
        step(1'b1, 16'hA1B2, 1'b0);
        chk("t1_b0", 32'(dout), 32'h A1);
        chk("t1_lvl1", 32'(level), 32'd1);
        step(1'b0, '0, 1'b1);
        chk("t1_b1", 32'(dout), 32'hB2);
        chk("t1_lvl2", 32'(level), 32'd1);
        step(1'b0, '0, 1'b1);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_lvl3", 32'(level), 32'd0);

        // fill, overflow, drain
        do_rst();
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
        step(1'b1, 16'hFFFF, 1'b0);
        chk("ovf_level", 32'(level), 32'd16);
`ifdef WCONV_ERR_CNT_EN
        chk("ovf_one", 32'(ovf_cnt), 32'd1);
`endif
        for (int i = 0; i < 32; i++) begin
            chk("drain_seq", 32'(dout), (i % 2 == 0) ? 32'd0 : 32'(i / 2));
            step(1'b0, '0, 1'b1);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // full with beat=1, write and pop together
        for (int i = 0; i < 16; i++) step(1'b1, 16'($urandom), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 16'hDEAD, 1'b1);
        chk("wp_level", 32'(level), 32'd15);
        chk("wp_full", 32'(full), 32'd0);
        step(1'b1, 16'hBEEF, 1'b0);
        chk("wp_refill", 32'(level), 32'd16);
        drain();

        // stream: one word per 2 clks, read every clk
        maxlvl = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 16'($urandom), 1'b1);
            if (level > maxlvl) maxlvl = level;
            step(1'b0, '0, 1'b1);
            if (level > maxlvl) maxlvl = level;
        end
        chk("stream_maxlvl", 32'(maxlvl <= 2), 32'd1);
        drain();
        step(1'b0, '0, 1'b1);

        // random traffic, write-heavy then read-heavy
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 3) == 0));
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) == 0), 16'($urandom),
                 1'($urandom_range(0, 3) != 0));

        // reset mid-word
        drain();
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 1'b0);
        step(1'b0, '0, 1'b1);
        do_rst();
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_level", 32'(level), 32'd0);
        chk("mr_full", 32'(full), 32'd0);
        step(1'b1, 16'h5A6B, 1'b0);
        chk("mr_b0", 32'(dout), 32'h5A);
        step(1'b0, '0, 1'b1);
        chk("mr_b1", 32'(dout), 32'h6B);
        step(1'b0, '0, 1'b1);
        check_outs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
